alu_share_arb: RTL and testbench

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

---
 rtl/alu_share_if.sv | 26 ++
 rtl/alu_share_arb.sv | 81 ++++++++
 tb/tb_alu_share_arb.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_if.sv
// alu_share_if: bundle of two requester ports, shared-ALU port and response port
interface alu_share_if #(parameter int W = 32, parameter int CW = 4);
   logic          req0_valid, req0_ready, req0_src;
   logic [W-1:0]  req0_data1, req0_data2, req0_imm;
   logic [CW-1:0] req0_ctrl;
   logic          req1_valid, req1_ready, req1_src;
   logic [W-1:0]  req1_data1, req1_data2, req1_imm;
   logic [CW-1:0] req1_ctrl;
   logic [W-1:0]  op1, op2, alu_result, rsp_result;
   logic [CW-1:0] alu_ctrl;
   logic          alu_active, rsp_valid, rsp_id, rsp_ready;
   modport slave (
      input  req0_valid, req0_src, req0_data1, req0_data2, req0_imm, req0_ctrl,
      input  req1_valid, req1_src, req1_data1, req1_data2, req1_imm, req1_ctrl,
      input  alu_result, rsp_ready,
      output req0_ready, req1_ready, op1, op2, alu_ctrl, alu_active,
      output rsp_valid, rsp_id, rsp_result
   );
   modport master (
      output req0_valid, req0_src, req0_data1, req0_data2, req0_imm, req0_ctrl,
      output req1_valid, req1_src, req1_data1, req1_data2, req1_imm, req1_ctrl,
      output alu_result, rsp_ready,
      input  req0_ready, req1_ready, op1, op2, alu_ctrl, alu_active,
      input  rsp_valid, rsp_id, rsp_result
   );
endinterface

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin arbiter sharing one combinational ALU between two requesters
module alu_share_arb #(
   parameter int W  = 32,
   parameter int CW = 4
) (
   input logic       clk,
   input logic       rst_n,
   alu_share_if.slave b
);
   typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
   state_t        state_q, state_d;
   logic          ptr_q, ptr_d, id_q, id_d, rsp_id_q, rsp_id_d, rsp_valid_q, rsp_valid_d;
   logic [W-1:0]  op1_q, op1_d, op2_q, op2_d, rsp_result_q, rsp_result_d;
   logic [CW-1:0] ctrl_q, ctrl_d;
   logic          gnt0, gnt1;
   // ptr_q names the requester that wins a tie; rst_n gating keeps ready low in reset
   assign gnt0 = rst_n && state_q == IDLE && b.req0_valid && (!b.req1_valid || !ptr_q);
   assign gnt1 = rst_n && state_q == IDLE && b.req1_valid && (!b.req0_valid || ptr_q);
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      id_d         = id_q;
      op1_d        = op1_q;
      op2_d        = op2_q;
      ctrl_d       = ctrl_q;
      rsp_id_d     = rsp_id_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      if (gnt0 || gnt1) begin
         state_d = EXEC;
         ptr_d   = gnt0;
         id_d    = gnt1;
         op1_d   = gnt1 ? b.req1_data1 : b.req0_data1;
         op2_d   = gnt1 ? (b.req1_src ? b.req1_imm : b.req1_data2)
                        : (b.req0_src ? b.req0_imm : b.req0_data2);
         ctrl_d  = gnt1 ? b.req1_ctrl : b.req0_ctrl;
      end
      if (state_q == EXEC) begin
         state_d      = HOLD;
         rsp_result_d = b.alu_result;
         rsp_id_d     = id_q;
         rsp_valid_d  = 1'b1;
      end
      if (state_q == HOLD && b.rsp_ready) begin
         state_d     = IDLE;
         rsp_valid_d = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         ptr_q        <= 1'b0;
         id_q         <= 1'b0;
         op1_q        <= '0;
         op2_q        <= '0;
         ctrl_q       <= '0;
         rsp_id_q     <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         id_q         <= id_d;
         op1_q        <= op1_d;
         op2_q        <= op2_d;
         ctrl_q       <= ctrl_d;
         rsp_id_q     <= rsp_id_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
      end
   end
   assign b.req0_ready = gnt0;
   assign b.req1_ready = gnt1;
   assign b.op1        = op1_q;
   assign b.op2        = op2_q;
   assign b.alu_ctrl   = ctrl_q;
   assign b.alu_active = state_q == EXEC;
   assign b.rsp_valid  = rsp_valid_q;
   assign b.rsp_id     = rsp_id_q;
   assign b.rsp_result = rsp_result_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed and random stimulus checked against a transaction-level model
module tb_alu_share_arb;
   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0, n_pass = 0;
   alu_share_if #(.W(32), .CW(4)) b();
   alu_share_arb #(.W(32), .CW(4)) dut (.clk(clk), .rst_n(rst_n), .b(b));
   always #5 clk = ~clk;

   function automatic logic [31:0] alu_fn(input logic [31:0] x, input logic [31:0] y, input logic [3:0] c);
      case (c[1:0])
         2'd0:    return x + y;
         2'd1:    return x - y;
         2'd2:    return x & y;
         default: return x ^ y;
      endcase
   endfunction
   assign b.alu_result = alu_fn(b.op1, b.op2, b.alu_ctrl);

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
   endtask

   // reference model: one transaction in flight, age counted in cycles since its grant
   bit          busy = 0, ptr = 0, any_v, g, e_id;
   int          age;
   logic [31:0] e_op1 = 0, e_op2 = 0, e_res;
   logic [3:0]  e_ctrl = 0;
   bit          gq[$];

   always @(negedge clk) begin
      if (!rst_n) begin
         busy = 0; ptr = 0; e_op1 = 0; e_op2 = 0; e_ctrl = 0;
         chk("rst_ready0", b.req0_ready, 0);
         chk("rst_ready1", b.req1_ready, 0);
         chk("rst_active", b.alu_active, 0);
         chk("rst_rsp_valid", b.rsp_valid, 0);
         chk("rst_rsp_id", b.rsp_id, 0);
         chk("rst_rsp_result", b.rsp_result, 0);
         chk("rst_op1", b.op1, 0);
         chk("rst_op2", b.op2, 0);
         chk("rst_ctrl", b.alu_ctrl, 0);
      end else begin
         chk("m_op1", b.op1, e_op1);
         chk("m_op2", b.op2, e_op2);
         chk("m_ctrl", b.alu_ctrl, e_ctrl);
         if (!busy) begin
            chk("m_idle_active", b.alu_active, 0);
            chk("m_idle_rsp_valid", b.rsp_valid, 0);
            any_v = b.req0_valid || b.req1_valid;
            g = (b.req0_valid && b.req1_valid) ? ptr : b.req1_valid;
            chk("m_ready0", b.req0_ready, any_v && !g);
            chk("m_ready1", b.req1_ready, any_v && g);
            if (any_v) begin
               e_op1  = g ? b.req1_data1 : b.req0_data1;
               e_op2  = g ? (b.req1_src ? b.req1_imm : b.req1_data2)
                          : (b.req0_src ? b.req0_imm : b.req0_data2);
               e_ctrl = g ? b.req1_ctrl : b.req0_ctrl;
               e_res  = alu_fn(e_op1, e_op2, e_ctrl);
               e_id   = g;
               ptr    = !g;
               busy   = 1;
               age    = 0;
               gq.push_back(g);
            end
         end else begin
            age++;
            chk("m_busy_ready0", b.req0_ready, 0);
            chk("m_busy_ready1", b.req1_ready, 0);
            chk("m_active", b.alu_active, age == 1);
            chk("m_rsp_valid", b.rsp_valid, age >= 2);
            if (age >= 2) begin
               chk("m_rsp_id", b.rsp_id, e_id);
               chk("m_rsp_result", b.rsp_result, e_res);
               if (b.rsp_ready) busy = 0;
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic rnd_fields();
      b.req0_data1 = $urandom; b.req0_data2 = $urandom; b.req0_imm = $urandom;
      b.req0_src = 1'($urandom_range(0, 1)); b.req0_ctrl = 4'($urandom_range(0, 15));
      b.req1_data1 = $urandom; b.req1_data2 = $urandom; b.req1_imm = $urandom;
      b.req1_src = 1'($urandom_range(0, 1)); b.req1_ctrl = 4'($urandom_range(0, 15));
   endtask

   task automatic clr();
      b.req0_valid = 0;
      b.req1_valid = 0;
      rnd_fields();
   endtask

   task automatic set_req(input bit id, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input bit src, input logic [3:0] ctrl);
      if (id) begin
         b.req1_valid = 1; b.req1_data1 = d1; b.req1_data2 = d2; b.req1_imm = imm;
         b.req1_src = src; b.req1_ctrl = ctrl;
      end else begin
         b.req0_valid = 1; b.req0_data1 = d1; b.req0_data2 = d2; b.req0_imm = imm;
         b.req0_src = src; b.req0_ctrl = ctrl;
      end
   endtask

   initial begin
      rst_n = 0;
      clr();
      b.rsp_ready = 1;
      b.req0_valid = 1;
      b.req1_valid = 1;
      #2;
      chk("init_ready0", b.req0_ready, 0);
      chk("init_ready1", b.req1_ready, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      clr();
      cyc();
      // single request, ALU adds
      set_req(0, 5, 7, 0, 0, 0);
      #2 chk("single_ready0", b.req0_ready, 1);
      cyc(); clr();
      #2 chk("single_op1", b.op1, 5);
      chk("single_op2", b.op2, 7);
      chk("single_active", b.alu_active, 1);
      cyc();
      #2 chk("single_rsp_valid", b.rsp_valid, 1);
      chk("single_result", b.rsp_result, 12);
      chk("single_id", b.rsp_id, 0);
      cyc();
      // immediate operand select
      set_req(1, 10, 99, 3, 1, 0);
      #2 chk("imm_ready1", b.req1_ready, 1);
      cyc(); clr();
      #2 chk("imm_op2", b.op2, 3);
      cyc();
      #2 chk("imm_id", b.rsp_id, 1);
      chk("imm_result", b.rsp_result, 13);
      cyc();
      // backpressure with a competing request held during HOLD
      b.rsp_ready = 0;
      set_req(0, 100, 23, 0, 0, 1);
      cyc(); clr();
      cyc();
      for (int i = 0; i < 5; i++) begin
         rnd_fields();
         b.req1_valid = 1;
         #2 chk("bp_valid", b.rsp_valid, 1);
         chk("bp_result", b.rsp_result, 77);
         chk("bp_id", b.rsp_id, 0);
         chk("bp_ready1", b.req1_ready, 0);
         cyc();
      end
      b.rsp_ready = 1;
      #2 chk("bp_accept_ready1", b.req1_ready, 0);
      cyc();
      #2 chk("bp_idle_ready1", b.req1_ready, 1);
      cyc(); clr();
      repeat (3) cyc();
      // full-scale operand wrapping to zero
      set_req(0, 32'hFFFF_FFFF, 1, 0, 0, 0);
      cyc(); clr();
      cyc();
      #2 chk("full_result", b.rsp_result, 0);
      cyc();
      // contention from reset: grants alternate starting with req0
      rst_n = 0;
      cyc();
      gq.delete();
      rnd_fields();
      b.req0_valid = 1;
      b.req1_valid = 1;
      rst_n = 1;
      for (int i = 0; i < 12; i++) begin
         cyc();
         rnd_fields();
      end
      for (int i = 0; i < 4; i++)
         chk($sformatf("cont_grant%0d", i), i < gq.size() ? 2'(gq[i]) : 2'd2, 2'(i % 2));
      clr();
      repeat (4) cyc();
      // reset during EXEC discards the operation
      b.req0_valid = 1;
      b.req1_valid = 1;
      cyc();
      #2 rst_n = 0;
      #1 chk("mid_active", b.alu_active, 0);
      chk("mid_op1", b.op1, 0);
      chk("mid_op2", b.op2, 0);
      chk("mid_rsp_valid", b.rsp_valid, 0);
      chk("mid_ready0", b.req0_ready, 0);
      cyc(); cyc();
      rst_n = 1;
      #2 chk("mid_after_ready0", b.req0_ready, 1);
      chk("mid_after_ready1", b.req1_ready, 0);
      cyc(); clr();
      repeat (3) cyc();
      // randomized traffic, including requesters that withdraw and random backpressure
      for (int i = 0; i < 400; i++) begin
         rnd_fields();
         b.req0_valid = $urandom_range(0, 9) < 6;
         b.req1_valid = $urandom_range(0, 9) < 6;
         b.rsp_ready  = $urandom_range(0, 9) < 7;
         cyc();
      end
      clr();
      b.rsp_ready = 1;
      repeat (5) cyc();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
